// File: rtl/bsg_link_ddr_rx_assembler.sv
// bsg_link_ddr_rx_assembler: deskews per-channel DDR words, decodes comma encoding,
// gathers beats into width_p-bit packets and returns credit as token toggles.
module bsg_link_ddr_rx_assembler #(
   parameter int width_p = 16,
   parameter int channel_width_p = 8,
   parameter int num_channels_p = 1,
   parameter int use_extra_data_bit_p = 0,
   parameter int use_encode_p = 0,
   parameter int lg_credit_to_token_decimation_p = 3,
   parameter int ch_fifo_els_p = 2
) (
   input  logic                                            core_clk_i,
   input  logic                                            core_link_reset_i,
   input  logic [num_channels_p-1:0]                       core_ch_valid_i,
   input  logic [num_channels_p-1:0][2*channel_width_p+1:0] core_ch_data_i,
   output logic [num_channels_p-1:0]                       core_ch_ready_o,
   output logic [width_p-1:0]                              core_data_o,
   output logic                                            core_valid_o,
   input  logic                                            core_ready_i,
   output logic [num_channels_p-1:0]                       core_token_r_o
);
   localparam int cw_lp = channel_width_p;
   localparam int ddr_width_lp = 2*cw_lp + use_extra_data_bit_p;
   localparam int beat_width_lp = ddr_width_lp*num_channels_p;
   localparam int piso_ratio_lp = width_p/beat_width_lp;
   localparam int beat_cnt_w_lp = piso_ratio_lp > 1 ? $clog2(piso_ratio_lp) : 1;
   localparam int ptr_w_lp = ch_fifo_els_p > 1 ? $clog2(ch_fifo_els_p) : 1;
   localparam int occ_w_lp = $clog2(ch_fifo_els_p+1);
   localparam int tok_w_lp = lg_credit_to_token_decimation_p;

   logic [num_channels_p-1:0] nonempty;
   logic [num_channels_p-1:0][ddr_width_lp-1:0] head_dec;
   logic beat, last_beat;
   logic valid_q, valid_d;
   logic [beat_cnt_w_lp-1:0] beat_cnt_q, beat_cnt_d;
   logic [width_p-1:0] sipo_q, sipo_d, data_q, data_d, assembled;

   // A beat needs every channel present and room in the output register.
   assign beat = (&nonempty) & (~valid_q | core_ready_i);

   for (genvar i = 0; i < num_channels_p; i++) begin : ch
      logic [2*cw_lp+1:0] mem_q [ch_fifo_els_p];
      logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
      logic [occ_w_lp-1:0] occ_q, occ_d;
      logic [tok_w_lp-1:0] tok_cnt_q, tok_cnt_d;
      logic token_q, token_d;
      logic [cw_lp:0] top;
      logic [cw_lp-1:0] bottom;
      logic nonzero, enq;
      logic [1:0] unused_bits;
      assign core_ch_ready_o[i] = occ_q < occ_w_lp'(ch_fifo_els_p);
      assign enq = core_ch_valid_i[i] & core_ch_ready_o[i];
      assign nonempty[i] = occ_q != '0;
      assign core_token_r_o[i] = token_q;
      assign {top, nonzero, bottom} = mem_q[rptr_q];
      assign unused_bits = {top[cw_lp], nonzero};
      // A zero-bottom comma carries only its upper half; the low half is restored as zeros.
      assign head_dec[i] = (use_encode_p != 0 && !nonzero)
         ? {top[ddr_width_lp-cw_lp-1:0], bottom[cw_lp/2-1], bottom[cw_lp-2:cw_lp/2], {(cw_lp/2){1'b0}}}
         : {top[ddr_width_lp-cw_lp-1:0], bottom};
      always_comb begin
         wptr_d = enq ? (wptr_q == ptr_w_lp'(ch_fifo_els_p-1) ? '0 : wptr_q + ptr_w_lp'(1)) : wptr_q;
         rptr_d = beat ? (rptr_q == ptr_w_lp'(ch_fifo_els_p-1) ? '0 : rptr_q + ptr_w_lp'(1)) : rptr_q;
         occ_d = occ_q + occ_w_lp'(enq) - occ_w_lp'(beat);
         tok_cnt_d = beat ? tok_cnt_q + tok_w_lp'(1) : tok_cnt_q;
         token_d = token_q ^ (beat & (&tok_cnt_q));
      end
      always_ff @(posedge core_clk_i) begin
         if (core_link_reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q <= '0;
            tok_cnt_q <= '0;
            token_q <= 1'b0;
         end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q <= occ_d;
            tok_cnt_q <= tok_cnt_d;
            token_q <= token_d;
         end
         if (enq) mem_q[wptr_q] <= core_ch_data_i[i];
      end
   end

   assign last_beat = beat_cnt_q == beat_cnt_w_lp'(piso_ratio_lp-1);

   always_comb begin
      assembled = sipo_q;
      for (int k = 0; k < piso_ratio_lp; k++)
         if (beat_cnt_q == beat_cnt_w_lp'(k)) assembled[k*beat_width_lp +: beat_width_lp] = head_dec;
      beat_cnt_d = beat ? (last_beat ? '0 : beat_cnt_q + beat_cnt_w_lp'(1)) : beat_cnt_q;
      sipo_d = beat ? assembled : sipo_q;
      data_d = (beat & last_beat) ? assembled : data_q;
      valid_d = (beat & last_beat) | (valid_q & ~core_ready_i);
   end

   always_ff @(posedge core_clk_i) begin
      if (core_link_reset_i) begin
         beat_cnt_q <= '0;
         sipo_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         sipo_q <= sipo_d;
         data_q <= data_d;
         valid_q <= valid_d;
      end
   end

   assign core_data_o = data_q;
   assign core_valid_o = valid_q;
endmodule

// File: tb/tb_bsg_link_ddr_rx_assembler.sv
// tb_bsg_link_ddr_rx_assembler: directed checks of decode, gearbox, skew,
// backpressure, token return and mid-packet reset.
module tb_bsg_link_ddr_rx_assembler;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_ab, v_ab, rdy_ab;
   logic [17:0] d_ab;
   logic [0:0] chr_a, chr_b, tok_a, tok_b;
   logic [15:0] data_a, data_b;
   logic val_a, val_b;
   logic rst_c, rdy_c, val_c;
   logic [1:0] v_c, chr_c, tok_c;
   logic [1:0][17:0] d_c;
   logic [63:0] data_c;
   int n_chk = 0;
   int n_pass = 0;

   bsg_link_ddr_rx_assembler #(.width_p(16)) dut_a (
      .core_clk_i(clk), .core_link_reset_i(rst_ab), .core_ch_valid_i(v_ab),
      .core_ch_data_i(d_ab), .core_ch_ready_o(chr_a), .core_data_o(data_a),
      .core_valid_o(val_a), .core_ready_i(rdy_ab), .core_token_r_o(tok_a));

   bsg_link_ddr_rx_assembler #(.width_p(16), .use_encode_p(1)) dut_b (
      .core_clk_i(clk), .core_link_reset_i(rst_ab), .core_ch_valid_i(v_ab),
      .core_ch_data_i(d_ab), .core_ch_ready_o(chr_b), .core_data_o(data_b),
      .core_valid_o(val_b), .core_ready_i(rdy_ab), .core_token_r_o(tok_b));

   bsg_link_ddr_rx_assembler #(.width_p(64), .num_channels_p(2)) dut_c (
      .core_clk_i(clk), .core_link_reset_i(rst_c), .core_ch_valid_i(v_c),
      .core_ch_data_i(d_c), .core_ch_ready_o(chr_c), .core_data_o(data_c),
      .core_valid_o(val_c), .core_ready_i(rdy_c), .core_token_r_o(tok_c));

   function automatic logic [17:0] mk(input logic [7:0] t, input logic nz, input logic [7:0] b);
      return {1'b0, t, nz, b};
   endfunction

   function automatic logic [15:0] bpx(input int k);
      return {8'(8'h10 + k), 8'(k*3)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int in_n, out_n, pkts, deqs;
      rst_ab = 1'b1; rst_c = 1'b1; v_ab = 1'b0; d_ab = '0; rdy_ab = 1'b1;
      v_c = '0; d_c = '0; rdy_c = 1'b1;
      step;
      step;
      rst_ab = 1'b0; rst_c = 1'b0;
      chk("rst_ready_a", 64'(chr_a), 64'(1));
      chk("rst_valid_a", 64'(val_a), 64'(0));
      chk("rst_data_a", 64'(data_a), 64'(0));
      chk("rst_token_a", 64'(tok_a), 64'(0));
      chk("rst_ready_c", 64'(chr_c), 64'(2'b11));
      chk("rst_valid_c", 64'(val_c), 64'(0));
      chk("rst_data_c", 64'(data_c), 64'(0));
      chk("rst_token_c", 64'(tok_c), 64'(0));

      v_ab = 1'b1; d_ab = mk(8'hAB, 1'b1, 8'hCD);
      step;
      v_ab = 1'b0;
      chk("byp_valid_t1", 64'(val_a), 64'(0));
      step;
      chk("byp_valid_t2", 64'(val_a), 64'(1));
      chk("byp_data", 64'(data_a), 64'(16'hABCD));
      chk("enc_nz1_byp_data", 64'(data_b), 64'(16'hABCD));
      step;
      chk("byp_drained", 64'(val_a), 64'(0));

      v_ab = 1'b1; d_ab = mk(8'h34, 1'b0, 8'hD1);
      step;
      d_ab = mk(8'h12, 1'b1, 8'h07);
      step;
      v_ab = 1'b0;
      chk("enc_zero_valid", 64'(val_b), 64'(1));
      chk("enc_zero_data", 64'(data_b), 64'(16'h3450));
      chk("noenc_zero_data", 64'(data_a), 64'(16'h34D1));
      step;
      chk("enc_nz_valid", 64'(val_b), 64'(1));
      chk("enc_nz_data", 64'(data_b), 64'(16'h1207));
      step;
      chk("enc_drained", 64'(val_b), 64'(0));

      in_n = 0; out_n = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 10) begin
            chk("bp_ready_low", 64'(chr_a), 64'(0));
            chk("bp_accepted", 64'(in_n), 64'(3));
            chk("bp_valid_held", 64'(val_a), 64'(1));
            chk("bp_data_held", 64'(data_a), 64'(bpx(0)));
         end
         rdy_ab = (c >= 10);
         v_ab = (in_n < 8);
         d_ab = mk(8'(8'h10 + in_n), 1'b1, 8'(in_n*3));
         if (val_a & rdy_ab) begin
            chk("bp_order", 64'(data_a), 64'(bpx(out_n)));
            out_n++;
         end
         if (v_ab & chr_a[0]) in_n++;
         step;
      end
      v_ab = 1'b0;
      chk("bp_out_count", 64'(out_n), 64'(8));
      chk("bp_ready_back", 64'(chr_a), 64'(1));

      rst_ab = 1'b1;
      step;
      rst_ab = 1'b0;
      chk("tok_rst", 64'(tok_a), 64'(0));
      for (int s = 1; s <= 20; s++) begin
         v_ab = (s <= 16);
         d_ab = mk(8'(s), 1'b1, 8'(s));
         step;
         deqs = (s - 1 > 16) ? 16 : s - 1;
         chk("tok_toggle", 64'(tok_a), 64'((deqs >> 3) & 1));
      end
      v_ab = 1'b0;

      v_c = 2'b10; d_c[1] = mk(8'h22, 1'b1, 8'h22); d_c[0] = '0;
      step;
      v_c = 2'b11; d_c[1] = mk(8'h44, 1'b1, 8'h44); d_c[0] = mk(8'h11, 1'b1, 8'h11);
      step;
      v_c = 2'b01; d_c[0] = mk(8'h33, 1'b1, 8'h33);
      step;
      v_c = 2'b00;
      chk("gb_valid_early", 64'(val_c), 64'(0));
      step;
      chk("gb_valid", 64'(val_c), 64'(1));
      chk("gb_data", data_c, 64'h4444_3333_2222_1111);
      pkts = 0;
      for (int s = 0; s < 6; s++) begin
         if (val_c & rdy_c) pkts++;
         step;
      end
      chk("gb_one_packet", 64'(pkts), 64'(1));

      v_c = 2'b11; d_c[1] = mk(8'hAA, 1'b1, 8'hAA); d_c[0] = mk(8'h55, 1'b1, 8'h55);
      step;
      d_c[1] = mk(8'h99, 1'b1, 8'h99); d_c[0] = mk(8'h66, 1'b1, 8'h66);
      step;
      v_c = 2'b00; rst_c = 1'b1;
      step;
      rst_c = 1'b0;
      chk("mr_valid", 64'(val_c), 64'(0));
      chk("mr_data", data_c, 64'h0);
      chk("mr_ready", 64'(chr_c), 64'(2'b11));
      chk("mr_token", 64'(tok_c), 64'(0));
      step;
      chk("mr_no_output", 64'(val_c), 64'(0));
      v_c = 2'b11; d_c[1] = mk(8'hBB, 1'b1, 8'hBB); d_c[0] = mk(8'hCC, 1'b1, 8'hCC);
      step;
      d_c[1] = mk(8'hDD, 1'b1, 8'hDD); d_c[0] = mk(8'hEE, 1'b1, 8'hEE);
      step;
      v_c = 2'b00;
      step;
      chk("mr_pkt_valid", 64'(val_c), 64'(1));
      chk("mr_pkt_data", data_c, 64'hDDDD_EEEE_BBBB_CCCC);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
